// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB, drives datapath strobes,
// counts retired instructions and halts on the addi x1,x0,12 / jalr x0,0(x1) pair.
module mc_ctrl_fsm #(
    parameter logic [31:0] HALT_PREV = 32'h00c00093,
    parameter logic [31:0] HALT_CUR  = 32'h00008067
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] INSTR,
    input  logic        BR_TAKEN,
    output logic        IR_WE,
    output logic        PC_WE,
    output logic [1:0]  PC_SEL,
    output logic        RF_WE,
    output logic        D_MEM_WEN,
    output logic [3:0]  D_MEM_BE,
    output logic [2:0]  STATE,
    output logic        HALT,
    output logic [31:0] NUM_INST
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_HLT = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t      state_reg;
    logic [31:0] ir_reg;
    logic [31:0] num_inst_reg;
    logic        prev_halt_reg;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_known;
    logic       halt_hit;
    logic       retire;

    assign opcode   = ir_reg[6:0];
    assign funct3   = ir_reg[14:12];
    assign rd       = ir_reg[11:7];
    assign halt_hit = (ir_reg == HALT_CUR) && prev_halt_reg;

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: is_known = 1'b1;
            default:                           is_known = 1'b0;
        endcase
    end

    // Strobes are a Moore function of state/IR; reset masks them in the same cycle
    // so an in-flight write never completes on the reset edge.
    always_comb begin
        IR_WE     = 1'b0;
        PC_WE     = 1'b0;
        PC_SEL    = 2'd0;
        RF_WE     = 1'b0;
        D_MEM_WEN = 1'b1;
        D_MEM_BE  = 4'b0000;
        retire    = 1'b0;
        case (state_reg)
            S_IF: IR_WE = 1'b1;
            S_ID: begin
                if (!halt_hit && !is_known) begin
                    PC_WE  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_EX: begin
                if (opcode == OP_BRANCH) begin
                    PC_WE  = 1'b1;
                    PC_SEL = BR_TAKEN ? 2'd1 : 2'd0;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (opcode == OP_STORE) begin
                    D_MEM_WEN = 1'b0;
                    case (funct3)
                        3'b000:  D_MEM_BE = 4'b0001;
                        3'b001:  D_MEM_BE = 4'b0011;
                        3'b010:  D_MEM_BE = 4'b1111;
                        default: D_MEM_BE = 4'b0000;
                    endcase
                    PC_WE  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                RF_WE  = (rd != 5'd0);
                PC_WE  = 1'b1;
                PC_SEL = (opcode == OP_JAL)  ? 2'd1 :
                         (opcode == OP_JALR) ? 2'd2 : 2'd0;
                retire = 1'b1;
            end
            default: ;
        endcase
        if (!RSTn) begin
            IR_WE     = 1'b0;
            PC_WE     = 1'b0;
            PC_SEL    = 2'd0;
            RF_WE     = 1'b0;
            D_MEM_WEN = 1'b1;
            D_MEM_BE  = 4'b0000;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg     <= S_IF;
            ir_reg        <= 32'd0;
            num_inst_reg  <= 32'd0;
            prev_halt_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IF: begin
                    ir_reg    <= INSTR;
                    state_reg <= S_ID;
                end
                S_ID: begin
                    if (halt_hit)      state_reg <= S_HLT;
                    else if (is_known) state_reg <= S_EX;
                    else               state_reg <= S_IF;
                end
                S_EX: begin
                    if (opcode == OP_BRANCH)
                        state_reg <= S_IF;
                    else if (opcode == OP_LOAD || opcode == OP_STORE)
                        state_reg <= S_MEM;
                    else
                        state_reg <= S_WB;
                end
                S_MEM:   state_reg <= (opcode == OP_STORE) ? S_IF : S_WB;
                S_WB:    state_reg <= S_IF;
                S_HLT:   state_reg <= S_HLT;
                default: state_reg <= S_IF;
            endcase
            if (retire) begin
                num_inst_reg  <= num_inst_reg + 32'd1;
                prev_halt_reg <= (ir_reg == HALT_PREV);
            end
        end
    end

    assign STATE    = state_reg;
    assign HALT     = (state_reg == S_HLT);
    assign NUM_INST = num_inst_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: each cycle's stimulus and expected outputs are
// queued per instruction, then replayed and compared one cycle at a time.
module tb_mc_ctrl_fsm;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] INSTR;
    logic        BR_TAKEN;
    logic        IR_WE, PC_WE, RF_WE, D_MEM_WEN, HALT;
    logic [1:0]  PC_SEL;
    logic [3:0]  D_MEM_BE;
    logic [2:0]  STATE;
    logic [31:0] NUM_INST;

    mc_ctrl_fsm dut (
        .CLK(CLK), .RSTn(RSTn), .INSTR(INSTR), .BR_TAKEN(BR_TAKEN),
        .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_SEL(PC_SEL), .RF_WE(RF_WE),
        .D_MEM_WEN(D_MEM_WEN), .D_MEM_BE(D_MEM_BE), .STATE(STATE),
        .HALT(HALT), .NUM_INST(NUM_INST)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  sel;
        logic        rf_we;
        logic        wen;
        logic [3:0]  be;
        logic        halt;
        logic [31:0] num;
    } obs_t;

    typedef struct {
        string       tag;
        logic        rstn;
        logic [31:0] instr;
        logic        br;
        obs_t        exp;
    } step_t;

    step_t q[$];
    int errors = 0;
    int checks = 0;

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d irwe=%b pcwe=%b sel=%0d rfwe=%b wen=%b be=%b halt=%b num=%0d",
                         o.st, o.ir_we, o.pc_we, o.sel, o.rf_we, o.wen, o.be, o.halt, o.num);
    endfunction

    task automatic p(input string tag, input logic rstn, input logic [31:0] instr, input logic br,
                     input logic [2:0] st, input logic ir_we, input logic pc_we, input logic [1:0] sel,
                     input logic rf_we, input logic wen, input logic [3:0] be, input logic halt,
                     input logic [31:0] num);
        step_t s;
        s.tag = tag; s.rstn = rstn; s.instr = instr; s.br = br;
        s.exp = '{st, ir_we, pc_we, sel, rf_we, wen, be, halt, num};
        q.push_back(s);
    endtask

    // Instruction-class expectations (num = count before this instruction retires)
    task automatic wb_class(input string tag, input logic [31:0] instr, input logic [31:0] num,
                            input logic [1:0] sel, input logic rf);
        p({tag, "_if"}, 1, instr, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, num);
        p({tag, "_id"}, 1, instr, 0, 3'd1, 0, 0, 2'd0, 0, 1, 4'b0, 0, num);
        p({tag, "_ex"}, 1, instr, 1, 3'd2, 0, 0, 2'd0, 0, 1, 4'b0, 0, num);
        p({tag, "_wb"}, 1, instr, 0, 3'd4, 0, 1, sel, rf, 1, 4'b0, 0, num);
    endtask

    task automatic run_queue();
        step_t s;
        obs_t  o;
        while (q.size() > 0) begin
            s = q.pop_front();
            RSTn = s.rstn; INSTR = s.instr; BR_TAKEN = s.br;
            #1;
            o = '{STATE, IR_WE, PC_WE, PC_SEL, RF_WE, D_MEM_WEN, D_MEM_BE, HALT, NUM_INST};
            checks++;
            assert (o === s.exp) else begin
                errors++;
                $error("FAIL %s: got %s, want %s", s.tag, fmt(o), fmt(s.exp));
            end
            $display("step %-12s %s", s.tag, fmt(o));
            @(negedge CLK);
        end
    endtask

    initial begin
        RSTn = 1'b0; INSTR = 32'd0; BR_TAKEN = 1'b0;
        @(negedge CLK);
        p("reset", 0, 32'd0, 0, 3'd0, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd0);
        run_queue();

        wb_class("addi", 32'h00500093, 32'd0, 2'd0, 1);
        run_queue();

        p("lw_if",  1, 32'h0000a103, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd1);
        p("lw_id",  1, 32'h0000a103, 0, 3'd1, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd1);
        p("lw_ex",  1, 32'h0000a103, 0, 3'd2, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd1);
        p("lw_mem", 1, 32'h0000a103, 0, 3'd3, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd1);
        p("lw_wb",  1, 32'h0000a103, 0, 3'd4, 0, 1, 2'd0, 1, 1, 4'b0, 0, 32'd1);
        run_queue();

        p("sh_if",  1, 32'h00209023, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd2);
        p("sh_id",  1, 32'h00209023, 0, 3'd1, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd2);
        p("sh_ex",  1, 32'h00209023, 0, 3'd2, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd2);
        p("sh_mem", 1, 32'h00209023, 0, 3'd3, 0, 1, 2'd0, 0, 0, 4'b0011, 0, 32'd2);
        run_queue();

        p("beqt_if", 1, 32'h00000463, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd3);
        p("beqt_id", 1, 32'h00000463, 0, 3'd1, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd3);
        p("beqt_ex", 1, 32'h00000463, 1, 3'd2, 0, 1, 2'd1, 0, 1, 4'b0, 0, 32'd3);
        p("beqn_if", 1, 32'h00000463, 1, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd4);
        p("beqn_id", 1, 32'h00000463, 1, 3'd1, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd4);
        p("beqn_ex", 1, 32'h00000463, 0, 3'd2, 0, 1, 2'd0, 0, 1, 4'b0, 0, 32'd4);
        p("nop_if",  1, 32'h0000007f, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd5);
        p("nop_id",  1, 32'h0000007f, 0, 3'd1, 0, 1, 2'd0, 0, 1, 4'b0, 0, 32'd5);
        run_queue();

        wb_class("jal",    32'h010000ef, 32'd6, 2'd1, 1);
        wb_class("jalr0",  32'h00010067, 32'd7, 2'd2, 0);
        // halt-pair second word without the first: plain jalr
        wb_class("jalrx1", 32'h00008067, 32'd8, 2'd2, 0);
        wb_class("addi12", 32'h00c00093, 32'd9, 2'd0, 1);
        run_queue();

        p("hlt_if",  1, 32'h00008067, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd10);
        p("hlt_id",  1, 32'h00008067, 0, 3'd1, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd10);
        p("hlt_0",   1, 32'h00500093, 1, 3'd5, 0, 0, 2'd0, 0, 1, 4'b0, 1, 32'd10);
        p("hlt_1",   1, 32'h0000007f, 0, 3'd5, 0, 0, 2'd0, 0, 1, 4'b0, 1, 32'd10);
        p("hlt_2",   1, 32'h00209023, 1, 3'd5, 0, 0, 2'd0, 0, 1, 4'b0, 1, 32'd10);
        p("hlt_rst", 0, 32'h00209023, 0, 3'd5, 0, 0, 2'd0, 0, 1, 4'b0, 1, 32'd10);
        run_queue();

        p("abt_if",  1, 32'h00209023, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd0);
        p("abt_id",  1, 32'h00209023, 0, 3'd1, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd0);
        p("abt_ex",  1, 32'h00209023, 0, 3'd2, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd0);
        p("abt_mem", 0, 32'h00209023, 0, 3'd3, 0, 0, 2'd0, 0, 1, 4'b0, 0, 32'd0);
        run_queue();

        wb_class("post", 32'h00500093, 32'd0, 2'd0, 1);
        p("post_cnt", 1, 32'h00500093, 0, 3'd0, 1, 0, 2'd0, 0, 1, 4'b0, 0, 32'd1);
        run_queue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter HALT_PREV, default 32'h00c00093, the first word of the halt pair (addi x1,x0,12).
REQ-002 SHALL have parameter HALT_CUR, default 32'h00008067, the second word of the halt pair (jalr x0,0(x1)).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port INSTR  input  32  instruction-memory read data, valid during IF.
REQ-006 SHALL have port BR_TAKEN  input  1  branch compare result from the ALU, valid during EX.
REQ-007 SHALL have port IR_WE  output  1  loads the instruction register with INSTR.
REQ-008 SHALL have port PC_WE  output  1  PC update strobe.
REQ-009 SHALL have port PC_SEL  output  2  PC source: 0 = PC+4, 1 = PC+IMM (branch/JAL), 2 = (RS1+IMM)&~1 (JALR).
REQ-010 SHALL have port RF_WE  output  1  register-file write enable.
REQ-011 SHALL have port D_MEM_WEN  output  1  data-memory write enable, active-low.
REQ-012 SHALL have port D_MEM_BE  output  4  data-memory byte enables for stores.
REQ-013 SHALL have port STATE  output  3  current FSM state encoding.
REQ-014 SHALL have port HALT  output  1  sticky halt indication.
REQ-015 SHALL have port NUM_INST  output  32  count of retired instructions.

Function
REQ-016 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, HLT=5; encodings 6 and 7 SHALL go to IF on the next clock.
REQ-017 SHALL assert IR_WE only in IF, and SHALL latch INSTR into an internal IR on that edge; IF->ID unconditionally.
REQ-018 SHALL decode in ID from the internal IR opcode (IR[6:0]): when IR==HALT_CUR and the previous retired instruction was HALT_PREV, go ID->HLT; otherwise ID->EX for LUI, AUIPC, JAL, JALR, branch, load, store, OP-IMM and OP.
REQ-019 SHALL treat an unknown opcode as a NOP in ID: PC_WE=1, PC_SEL=0, no RF or memory write, retire, go to IF.
REQ-020 SHALL handle EX as follows: branch -> PC_WE=1, PC_SEL=1 if BR_TAKEN else 0, retire, go to IF; load/store -> MEM; all others -> WB.
REQ-021 SHALL handle MEM as follows: store -> D_MEM_WEN=0 for exactly this cycle, D_MEM_BE from funct3 (000->0001, 001->0011, 010->1111, other->0000), PC_WE=1, PC_SEL=0, retire, go to IF; load -> D_MEM_WEN=1, go to WB.
REQ-022 SHALL handle WB as follows: RF_WE=1 (suppressed when rd=x0), PC_WE=1, PC_SEL=1 for JAL, 2 for JALR, 0 otherwise, retire, go to IF.
REQ-023 SHALL assert RF_WE, PC_WE and D_MEM_WEN=0 only in the cycles named above; these strobes are otherwise RF_WE=0, PC_WE=0, D_MEM_WEN=1.
REQ-024 SHALL increment NUM_INST by 1 on each retire edge and wrap from 32'hffffffff to 0.
REQ-025 SHALL record a "previous retired instruction was HALT_PREV" flag on each retire and clear it on any other retire.
REQ-026 SHALL, once in HLT, hold HALT=1, assert no strobes, stop NUM_INST (the halt jalr does not count), and leave HLT only on reset.
REQ-027 SHALL produce outputs as a Moore function of state and IR only, except PC_SEL in EX, which also depends on BR_TAKEN.
REQ-028 SHALL give per-class latency from IF: branch 3, store 4, ALU/LUI/AUIPC/JAL/JALR 4, load 5 cycles.

Reset
REQ-029 SHALL, on a clock edge with RSTn=0, set STATE=IF, IR=0, NUM_INST=0, HALT=0, halt flag=0, with RF_WE=0, PC_WE=0, IR_WE=0, D_MEM_WEN=1, D_MEM_BE=0 and PC_SEL=0 in the same cycle.
REQ-030 SHALL abort any in-flight instruction when reset is asserted in any state, without completing its write.

Verification
REQ-031 SHALL verify: INSTR=32'h00500093 (addi) -> states IF,ID,EX,WB; RF_WE=1 only in WB; NUM_INST 0->1.
REQ-032 SHALL verify: lw (32'h0000a103) -> 5 cycles, D_MEM_WEN stays 1 throughout, RF_WE=1 in WB.
REQ-033 SHALL verify: sh (32'h00209023) -> D_MEM_WEN=0 and D_MEM_BE=0011 only in MEM, RF_WE never 1.
REQ-034 SHALL verify: beq with BR_TAKEN=1 -> PC_SEL=1 in EX; with BR_TAKEN=0 -> PC_SEL=0; both retire in 3 cycles.
REQ-035 SHALL verify: 32'h00c00093 followed by 32'h00008067 -> STATE=HLT and HALT=1 after the second ID, NUM_INST frozen; RSTn=0 returns STATE=IF and NUM_INST=0.
REQ-036 SHALL verify: RSTn=0 during MEM of a store -> D_MEM_WEN=1 on that edge and STATE=IF next cycle.
